// File: rtl/pe_result_collector.sv
// pe_result_collector
// Sits directly behind the SNN convolution PEs. Gathers exactly one result
// per PE for the current timestep. Each result carries a residue, an output
// spike and a timestep. When every PE has reported, the collector emits one
// aggregated spike map and the unsigned sum of the residues.
//
// Packets are dropped and flagged when they are malformed (PE id out of
// range), carry the wrong timestep, or repeat a PE already seen this
// timestep.
//
// Optional feature: define RESULT_COLLECTOR_ERRCNT_EN to add an 8-bit
// saturating error counter on output err_count.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. A sender holds its data stable while valid=1 && ready=0. The
// collector never takes back out_valid before out_ready is seen.
module pe_result_collector #(
    parameter int NUM_PE       = 9,
    parameter int OUTPUT_WIDTH = 13,
    parameter int PKT_WIDTH    = 53,
    parameter int SUM_WIDTH    = OUTPUT_WIDTH + 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PKT_WIDTH-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NUM_PE-1:0]    out_spikes,
    output logic                 out_timestep,
    output logic [SUM_WIDTH-1:0] out_residue_sum,
    output logic                 err_id,
    output logic                 err_ts,
    output logic                 err_dup
`ifdef RESULT_COLLECTOR_ERRCNT_EN
    ,
    output logic [7:0]           err_count
`endif
);

    // Bit positions of the packet fields
    localparam int RES_LSB = 14;
    localparam int SPK_BIT = 9;
    localparam int TS_BIT  = 8;
    localparam int ID_LSB  = 4;

    typedef enum logic {
        S_COLLECT = 1'b0,
        S_EMIT    = 1'b1
    } state_t;

    state_t state_q, state_d;

    // Per-timestep accumulation state
    logic [NUM_PE-1:0]    seen_q,   seen_d;
    logic [NUM_PE-1:0]    spikes_q, spikes_d;
    logic [SUM_WIDTH-1:0] sum_q,    sum_d;
    logic                 exp_ts_q, exp_ts_d;

    // Registered one-cycle error pulses
    logic err_id_q,  err_id_d;
    logic err_ts_q,  err_ts_d;
    logic err_dup_q, err_dup_d;

    // Decoded packet fields
    logic [OUTPUT_WIDTH-1:0] pkt_residue;
    logic                    pkt_spike;
    logic                    pkt_ts;
    logic [3:0]              pkt_id;

    // Classification of the current transfer
    logic [NUM_PE-1:0] id_onehot;
    logic [NUM_PE-1:0] seen_next;
    logic              id_valid;
    logic              xfer;
    logic              drop_id;
    logic              drop_ts;
    logic              drop_dup;
    logic              take;
    logic              last_take;
    logic              emit_done;

    // Fields the collector does not use
    logic unused_pkt_bits;

    // Split the incoming packet into its fields
    assign pkt_residue = in_data[RES_LSB +: OUTPUT_WIDTH];
    assign pkt_spike   = in_data[SPK_BIT];
    assign pkt_ts      = in_data[TS_BIT];
    assign pkt_id      = in_data[ID_LSB +: 4];

    assign unused_pkt_bits = ^{in_data[PKT_WIDTH-1:RES_LSB+OUTPUT_WIDTH],
                               in_data[RES_LSB-1:SPK_BIT+1],
                               in_data[ID_LSB-1:0]};

    // One-hot decode of the PE id. An all-zero result means the id is >= NUM_PE.
    always_comb begin
        id_onehot = '0;
        for (int i = 0; i < NUM_PE; i++) begin
            id_onehot[i] = (pkt_id == 4'(i));
        end
    end

    assign id_valid  = |id_onehot;
    assign xfer      = in_valid && in_ready;
    assign seen_next = seen_q | id_onehot;
    assign emit_done = out_valid && out_ready;

    // Classify a transfer. The checks are applied in priority order:
    // bad id, then wrong timestep, then duplicate.
    always_comb begin
        drop_id  = 1'b0;
        drop_ts  = 1'b0;
        drop_dup = 1'b0;
        take     = 1'b0;
        if (xfer) begin
            if (!id_valid) begin
                drop_id = 1'b1;
            end else if (pkt_ts != exp_ts_q) begin
                drop_ts = 1'b1;
            end else if (|(seen_q & id_onehot)) begin
                drop_dup = 1'b1;
            end else begin
                take = 1'b1;
            end
        end
    end

    // This accepting edge completes the set of PEs for the timestep
    assign last_take = take && (&seen_next);

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_COLLECT: if (last_take) state_d = S_EMIT;
            S_EMIT:    if (out_ready) state_d = S_COLLECT;
            default:   state_d = S_COLLECT;
        endcase
    end

    // FSM outputs. Both are decoded directly from the state register.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            S_COLLECT: in_ready  = 1'b1;
            S_EMIT:    out_valid = 1'b1;
            default:   in_ready  = 1'b0;
        endcase
    end

    // Next values of the accumulation state and the error pulses.
    // The emit handshake only happens in EMIT and a take only happens in
    // COLLECT, so the two never occur in the same cycle.
    always_comb begin
        seen_d    = seen_q;
        spikes_d  = spikes_q;
        sum_d     = sum_q;
        exp_ts_d  = exp_ts_q;
        err_id_d  = drop_id;
        err_ts_d  = drop_ts;
        err_dup_d = drop_dup;
        if (emit_done) begin
            seen_d   = '0;
            spikes_d = '0;
            sum_d    = '0;
            exp_ts_d = ~exp_ts_q;
        end else if (take) begin
            seen_d   = seen_next;
            spikes_d = (spikes_q & ~id_onehot) | (id_onehot & {NUM_PE{pkt_spike}});
            sum_d    = sum_q + SUM_WIDTH'(pkt_residue);
        end
    end

    // Accumulation and error-pulse registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seen_q    <= '0;
            spikes_q  <= '0;
            sum_q     <= '0;
            exp_ts_q  <= 1'b0;
            err_id_q  <= 1'b0;
            err_ts_q  <= 1'b0;
            err_dup_q <= 1'b0;
        end else begin
            seen_q    <= seen_d;
            spikes_q  <= spikes_d;
            sum_q     <= sum_d;
            exp_ts_q  <= exp_ts_d;
            err_id_q  <= err_id_d;
            err_ts_q  <= err_ts_d;
            err_dup_q <= err_dup_d;
        end
    end

    // The running spike map and sum can be seen during collection.
    // They are stable while EMIT waits for the downstream stage.
    assign out_spikes      = spikes_q;
    assign out_timestep    = exp_ts_q;
    assign out_residue_sum = sum_q;
    assign err_id          = err_id_q;
    assign err_ts          = err_ts_q;
    assign err_dup         = err_dup_q;

`ifdef RESULT_COLLECTOR_ERRCNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;
    logic       any_drop;

    assign any_drop = drop_id || drop_ts || drop_dup;

    // Saturating count of dropped packets. It counts on the dropping edge,
    // so it stays in step with the err_* pulse registers.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (any_drop && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    // Error counter register. Only rst clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_count = err_cnt_q;
`endif

endmodule
